// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M multiply/divide opcodes, FSM states and sign helpers
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Conditional two's-complement: absolute value on entry, sign restore on exit.
    function automatic logic [MULDIV_XLEN-1:0] magnitude(input logic [MULDIV_XLEN-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*MULDIV_XLEN-1:0] negate(input logic [2*MULDIV_XLEN-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M unit: shift-add multiply, restoring divide, sign fix-up
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic            write,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e       state;
    muldiv_op_e          op_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                sign_a;
    logic                sign_b;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       count;

    muldiv_op_e          op_in;
    logic                in_sign_a;
    logic                in_sign_b;
    logic                div_by_zero;
    logic                div_overflow;
    logic [XLEN-1:0]     special_res;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     fix_res;

    assign busy  = (state != IDLE);
    assign write = done;

    assign op_in     = muldiv_op_e'(op);
    assign in_sign_a = op_signed_a(op_in) & rs1[XLEN-1];
    assign in_sign_b = op_signed_b(op_in) & rs2[XLEN-1];

    assign div_by_zero  = is_div(op_in) && (rs2 == '0);
    assign div_overflow = (op_in == OP_DIV || op_in == OP_REM)
                          && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    always_comb begin
        special_res = '0;
        if (div_by_zero)
            special_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : rs1;
        else if (op_in == OP_DIV)
            special_res = {1'b1, {(XLEN-1){1'b0}}};
    end

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_trial = div_shift - {1'b0, b_mag};

    assign prod = (sign_a ^ sign_b) ? negate(acc) : acc;
    assign quot = magnitude(acc[XLEN-1:0], sign_a ^ sign_b);
    assign rem  = magnitude(acc[2*XLEN-1:XLEN], sign_a);

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:                     fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_res = quot;
            default:                    fix_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            result  <= '0;
            rd_addr <= '0;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            acc     <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        op_q   <= op_in;
                        rd_q   <= rd_addr_in;
                        a_mag  <= magnitude(rs1, in_sign_a);
                        b_mag  <= magnitude(rs2, in_sign_b);
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        count  <= '0;
                        if (div_by_zero || div_overflow) begin
                            result  <= special_res;
                            rd_addr <= rd_addr_in;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, is_div(op_in) ? magnitude(rs1, in_sign_a)
                                                                  : magnitude(rs2, in_sign_b)};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        if (is_div(op_q)) begin
                            if (!div_trial[XLEN])
                                acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                            else
                                acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        count <= count + CW'(1);
                        if (count == CW'(XLEN-1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        result  <= fix_res;
                        rd_addr <= rd_q;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes rs1/rs2 operand values read from the register file and produces a result, destination address and one-cycle write strobe for the register file write port (rd, rd_addr, write).
- The core stalls while busy is high.
- Runs radix-2 shift-add multiply and restoring divide on operand magnitudes, then sign-corrects.

Parameters:
XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
kill  input  1  abort current operation (pipeline flush)
op  input  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
rs1  input  XLEN  operand A, sampled with start
rs2  input  XLEN  operand B, sampled with start
rd_addr_in  input  5  destination register, sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result is valid
write  output  1  register-file write enable; equals done
result  output  XLEN  final result; held until the next done
rd_addr  output  5  destination for result; held with result

Behaviour:
- Reset (rst_n low at clk edge):
  - state goes to IDLE.
  - busy, done, write, result, rd_addr and all internal registers go to 0.
  - Applies mid-operation: any operation in flight is discarded with no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and kill=0: latch op, rd_addr_in, |rs1|, |rs2| and sign flags.
  - If a special case applies, load the result and go to DONE; otherwise clear count and go to CALC.
  - start=0 or kill=1: stay in IDLE.
- CALC: one iteration per cycle for XLEN cycles (count 0..XLEN-1), then go to FIX.
- FIX: apply sign correction, select the high or low half / quotient or remainder, load result, go to DONE.
- DONE:
  - done=write=1 for exactly one cycle, then go to IDLE.
  - start is ignored while in DONE.
- Latency, measured from the start-accepting edge:
  - Normal operation: done high in cycle XLEN+2 (34).
  - Special case: done high in cycle 1.
  - Back-to-back operations: the next start is accepted on the first cycle back in IDLE.
- kill:
  - In CALC or FIX: go to IDLE next edge; no done; result and rd_addr are unchanged.
  - In DONE: ignored; the write completes.
  - kill and start together in IDLE: kill wins.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Multiply:
  - 2*XLEN-bit accumulator over unsigned magnitudes.
  - Negate the full 2*XLEN product if the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring division over magnitudes.
  - Quotient negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Special cases, resolved in IDLE and not iterated:
  - rs2==0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: returns 0x80000000.
  - REM with the same operands: returns 0.
- rd_addr 0 is passed through as-is; the register file's x0 read masking makes that write harmless.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e enum on 3 bits, matching funct3 encodings.
  - muldiv_state_e (IDLE, CALC, FIX, DONE).
  - Helper functions is_div(op) and op_signed_a/b(op).
- No sub-module: datapath and FSM stay in a single module.
- Magnitude and negate are package functions.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, done/write pulse exactly at cycle 34; busy high cycles 1-34.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
- DIV x/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done at cycle 1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- kill asserted at cycle 10 of a DIV -> no done; result and rd_addr keep their previous values; busy low next cycle; a new start is accepted immediately.
- rst_n low at cycle 20 of a MUL -> all outputs 0 next edge, no done; start while in DONE is ignored; start+kill in IDLE -> no operation starts.
